// File: rtl/char_sequencer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : char_seq_pkg                                          |
// | Purpose  : Shared constants and state encoding for the character |
// |            sequencer (character width, default sizes, FSM codes). |
// | Ports    : none (package)                                        |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package char_seq_pkg;

  localparam int CHAR_W         = 7;
  localparam int DEFAULT_DEPTH  = 16;
  localparam int DEFAULT_HOLD_W = 8;

  // Sequencer state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EMIT = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/char_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : char_sequencer_if                                     |
// | Purpose  : Host write channel plus animator character channel.   |
// | Ports    : wr_valid/wr_char/wr_ready  host append handshake      |
// |            char_valid/char_out       animator character strobe  |
// |            master = host/animator side, slave = sequencer side   |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
interface char_sequencer_if;
  import char_seq_pkg::*;

  logic              wr_valid;
  logic [CHAR_W-1:0] wr_char;
  logic              wr_ready;
  logic              char_valid;
  logic [CHAR_W-1:0] char_out;

  modport master (
    output wr_valid,
    output wr_char,
    input  wr_ready,
    input  char_valid,
    input  char_out
  );

  modport slave (
    input  wr_valid,
    input  wr_char,
    output wr_ready,
    output char_valid,
    output char_out
  );

endinterface
`default_nettype wire

// File: rtl/char_sequencer_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : char_buffer                                           |
// | Purpose  : DEPTH x CHAR_W message store. Appends at index count, |
// |            combinational read at rd_ptr.                         |
// | Ports    : clk, rst_n (sync, active low), ena, clear, wr_en,     |
// |            wr_data, rd_ptr -> rd_data, count                     |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module char_buffer
  import char_seq_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [CHAR_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_ptr,
  output logic [CHAR_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [CHAR_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic              w_store;

  // Guard against overfill locally as well as in the sequencer
  assign w_store = ena & ~clear & wr_en & (r_count < C_DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (ena) begin
      if (clear) begin
        r_count <= '0;
      end else if (w_store) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  // Contents are don't-care after reset, so the array is not reset
  always_ff @(posedge clk) begin
    if (rst_n && w_store) begin
      r_mem[r_count[PTR_W-1:0]] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_ptr];
  assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/char_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : char_sequencer                                        |
// | Purpose  : Buffers a host-written message and plays it out to    |
// |            the animator, one character per hold period of frame  |
// |            ticks, one-shot or looped.                            |
// | Ports    : clk, rst_n (sync, active low), ena, frame_tick,       |
// |            clear, start, stop, loop, hold_frames,                |
// |            busy, count, bus (char_sequencer_if.slave)            |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module char_sequencer
  import char_seq_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int HOLD_W = DEFAULT_HOLD_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    frame_tick,
  input  logic                    clear,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop,
  input  logic [HOLD_W-1:0]       hold_frames,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  count,
  char_sequencer_if.slave         bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  state_t            r_state;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [CHAR_W-1:0] r_char_out;

  logic [CNT_W-1:0]  w_count;
  logic [CHAR_W-1:0] w_rd_data;
  logic              w_wr_ready;
  logic              w_wr_accept;
  logic [CNT_W-1:0]  w_post_count;
  logic [HOLD_W-1:0] w_hold_load;
  logic              w_last;
  logic              w_emit;

  char_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .clear   (clear),
    .wr_en   (w_wr_accept),
    .wr_data (bus.wr_char),
    .rd_ptr  (r_rd_ptr),
    .rd_data (w_rd_data),
    .count   (w_count)
  );

  assign w_wr_ready  = ena & (r_state == ST_IDLE) & (w_count < C_DEPTH) & ~clear;
  assign w_wr_accept = bus.wr_valid & w_wr_ready;

  // A write coinciding with start is part of the message being played
  assign w_post_count = w_count + CNT_W'(w_wr_accept);

  // Zero hold is treated as one frame
  assign w_hold_load = (hold_frames == '0) ? HOLD_W'(1) : hold_frames;

  assign w_last = (CNT_W'(r_rd_ptr) + CNT_W'(1)) >= w_count;

  assign w_emit = ena & (r_state == ST_EMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rd_ptr   <= '0;
      r_hold_cnt <= '0;
      r_char_out <= '0;
    end else if (ena) begin
      // The character strobed this cycle stays on char_out afterwards,
      // even if the playback is aborted in the same cycle.
      if (r_state == ST_EMIT) begin
        r_char_out <= w_rd_data;
      end

      if (clear || stop) begin
        r_state  <= ST_IDLE;
        r_rd_ptr <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && (w_post_count != '0)) begin
              r_state  <= ST_EMIT;
              r_rd_ptr <= '0;
            end
          end
          ST_EMIT: begin
            r_hold_cnt <= w_hold_load;
            r_state    <= ST_HOLD;
          end
          ST_HOLD: begin
            if (frame_tick) begin
              if (r_hold_cnt <= HOLD_W'(1)) begin
                if (!w_last) begin
                  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                  r_state  <= ST_EMIT;
                end else if (loop) begin
                  r_rd_ptr <= '0;
                  r_state  <= ST_EMIT;
                end else begin
                  r_rd_ptr <= '0;
                  r_state  <= ST_IDLE;
                end
              end else begin
                r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
              end
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_rd_ptr <= '0;
          end
        endcase
      end
    end
  end

  // The new character is presented in the same cycle as its strobe
  assign bus.char_valid = w_emit;
  assign bus.char_out   = w_emit ? w_rd_data : r_char_out;
  assign bus.wr_ready   = w_wr_ready;
  assign busy           = (r_state != ST_IDLE);
  assign count          = w_count;

endmodule
`default_nettype wire
